// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line and memory-arbiter enums.
package lc3b_types;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_rr_grant2.sv
// Two-way round-robin picker: a lone requester always wins; on a conflict
// the side that did not win last time gets the grant.
module rr_grant2
  import lc3b_types::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);

  // Pick D when it is alone, or when both ask and I was served last.
  always_comb begin
    grant_valid = req_i | req_d;
    grant       = GRANT_I;
    if (req_d && (!req_i || (last_grant == GRANT_I))) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the I-cache and the D-cache.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; arbitrate and launch the command on grant
//   BUSY_I | I-cache read in flight, pmem_* held until pmem_resp
//   BUSY_D | D-cache read or write-back in flight
//   RESP_I | one-cycle i_resp pulse; requester drops i_read this edge
//   RESP_D | one-cycle d_resp pulse; requester drops its request
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_WORD_W,
  parameter int LINE_WIDTH = LC3B_LINE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state_q, state_d;
  arb_grant_t last_grant_q, last_grant_d;
  arb_grant_t grant;
  logic       grant_valid;

  logic                  pmem_read_d, pmem_write_d;
  logic [ADDR_WIDTH-1:0] pmem_address_d;
  logic [LINE_WIDTH-1:0] pmem_wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_d, d_rdata_d;

  rr_grant2 u_rr_grant2 (
    .req_i       (i_read),
    .req_d       (d_read | d_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Next state, next memory command and returned-line capture.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read;
    pmem_write_d   = pmem_write;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
    i_rdata_d      = i_rdata;
    d_rdata_d      = d_rdata;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant;
          if (grant == GRANT_I) begin
            pmem_address_d = i_address;
            pmem_read_d    = 1'b1;
            pmem_write_d   = 1'b0;
            state_d        = BUSY_I;
          end else begin
            // d_read together with d_write is illegal; the write wins.
            pmem_address_d = d_address;
            pmem_wdata_d   = d_wdata;
            pmem_write_d   = d_write;
            pmem_read_d    = ~d_write;
            state_d        = BUSY_D;
          end
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          i_rdata_d    = pmem_rdata;
          state_d      = RESP_I;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          if (pmem_read) begin
            d_rdata_d = pmem_rdata;
          end
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered memory command; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
      i_rdata      <= i_rdata_d;
      d_rdata      <= d_rdata_d;
    end
  end

  // Completion pulses are simply the one-cycle response states.
  always_comb begin
    i_resp = (state_q == RESP_I);
    d_resp = (state_q == RESP_D);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cache requests, a latency-programmable
// memory, a transaction-level reference model checked every cycle, and
// hand-computed literal expectations for the key scenarios.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read, d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 2;
  int mem_cnt = 0;

  mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [15:0] a);
    if (a == 16'h0040) return {4{32'hDEAD_BEEF}};
    return {8{a ^ 16'h5A5A}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers pmem_resp in the mem_lat-th cycle a command is held,
  // and drives junk on pmem_rdata in every other cycle.
  always @(negedge clk) begin
    if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(pmem_address);
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      mem_cnt    = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Reference model: one transaction record plus a pending-response flag.
  bit           m_valid = 0;
  bit           m_fresh, m_active, m_side_d, m_write, m_last_d;
  bit           m_resp_i, m_resp_d, m_want_i, m_want_d;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata, m_rd_i, m_rd_d;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_fresh = 1; m_active = 0; m_last_d = 0;
      m_resp_i = 0; m_resp_d = 0;
      m_addr = '0; m_wdata = '0; m_rd_i = '0; m_rd_d = '0;
    end else if (m_resp_i || m_resp_d) begin
      m_resp_i = 0; m_resp_d = 0;
    end else if (m_active) begin
      if (pmem_resp) begin
        m_active = 0;
        if (m_side_d) begin
          m_resp_d = 1;
          if (!m_write) m_rd_d = pmem_rdata;
        end else begin
          m_resp_i = 1;
          m_rd_i   = pmem_rdata;
        end
      end
    end else begin
      m_want_i = i_read;
      m_want_d = d_read | d_write;
      if (m_want_i || m_want_d) begin
        m_side_d = m_want_d && (!m_want_i || !m_last_d);
        m_last_d = m_side_d;
        m_active = 1;
        m_fresh  = 0;
        if (m_side_d) begin
          m_write = d_write;
          m_addr  = d_address;
          m_wdata = d_wdata;
        end else begin
          m_write = 0;
          m_addr  = i_address;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pmem_read",  128'(pmem_read),  128'(m_active && !m_write));
      chk("pmem_write", 128'(pmem_write), 128'(m_active && m_write));
      chk("i_resp",     128'(i_resp),     128'(m_resp_i));
      chk("d_resp",     128'(d_resp),     128'(m_resp_d));
      chk("i_rdata",    i_rdata, m_rd_i);
      chk("d_rdata",    d_rdata, m_rd_d);
      if (m_active || m_fresh) begin
        chk("pmem_address", 128'(pmem_address), 128'(m_addr));
        if (m_write || m_fresh) chk("pmem_wdata", pmem_wdata, m_wdata);
      end
    end
  end

  // Wait (bounded) for a side's resp, then drop that side's request.
  task automatic wait_resp(input bit side_d, output int cycles);
    bit seen = 0;
    cycles = 0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      seen = side_d ? (d_resp === 1'b1) : (i_resp === 1'b1);
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: side_d=%0d no resp within %0d cycles", side_d, cycles);
    end
    if (side_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  initial begin
    int c;
    int pulses;
    rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    // 1: reset held two cycles with i_read asserted
    i_read = 1'b1; i_address = 16'h1230; mem_lat = 2;
    repeat (2) @(negedge clk);
    chk("t1_rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("t1_rst_i_resp", 128'(i_resp), 128'(0));
    chk("t1_rst_i_rdata", i_rdata, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_read", 128'(pmem_read), 128'(1));
    chk("t1_first_addr", 128'(pmem_address), 128'(16'h1230));
    wait_resp(0, c);

    // 2: lone I read, 3-cycle memory
    @(negedge clk);
    mem_lat = 3; i_address = 16'h0040; i_read = 1'b1;
    wait_resp(0, c);
    chk("t2_latency", 128'(c), 128'(4));
    chk("t2_i_rdata", i_rdata, {4{32'hDEAD_BEEF}});
    chk("t2_read_low_in_resp", 128'(pmem_read), 128'(0));
    @(negedge clk);
    chk("t2_resp_one_cycle", 128'(i_resp), 128'(0));

    // 3: simultaneous requests after reset, then alternation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_lat = 2;
    i_address = 16'h0200; d_address = 16'h8000;
    i_read = 1'b1; d_read = 1'b1;
    @(negedge clk);
    chk("t3_d_first_read", 128'(pmem_read), 128'(1));
    chk("t3_d_first_addr", 128'(pmem_address), 128'(16'h8000));
    wait_resp(1, c);
    @(negedge clk);
    d_address = 16'h8010; d_read = 1'b1;
    @(negedge clk);
    chk("t3_i_next_addr", 128'(pmem_address), 128'(16'h0200));
    chk("t3_i_next_read", 128'(pmem_read), 128'(1));
    wait_resp(0, c);
    wait_resp(1, c);
    chk("t3_d_rdata", d_rdata, line_of(16'h8010));

    // 4: D write-back
    @(negedge clk);
    d_address = 16'h0100;
    d_wdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    d_write = 1'b1;
    @(negedge clk);
    chk("t4_pmem_write", 128'(pmem_write), 128'(1));
    chk("t4_pmem_wdata", pmem_wdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    chk("t4_pmem_addr", 128'(pmem_address), 128'(16'h0100));
    wait_resp(1, c);
    chk("t4_latency", 128'(c), 128'(2));
    chk("t4_d_rdata_kept", d_rdata, line_of(16'h8010));

    // 5: illegal read+write handled as a write
    @(negedge clk);
    d_address = 16'h0300; d_wdata = {4{32'hCAFE_F00D}};
    d_read = 1'b1; d_write = 1'b1;
    @(negedge clk);
    chk("t5_is_write", 128'(pmem_write), 128'(1));
    chk("t5_not_read", 128'(pmem_read), 128'(0));
    wait_resp(1, c);
    @(negedge clk);
    chk("t5_idle_write", 128'(pmem_write), 128'(0));
    chk("t5_idle_read", 128'(pmem_read), 128'(0));

    // 6: reset in the middle of a D write-back
    mem_lat = 6; d_address = 16'h0400; d_wdata = {8{16'h1357}};
    d_write = 1'b1;
    @(negedge clk);
    chk("t6_busy_write", 128'(pmem_write), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_abort_write", 128'(pmem_write), 128'(0));
    d_write = 1'b0; rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_resp === 1'b1) pulses++;
    end
    chk("t6_no_d_resp", 128'(pulses), 128'(0));
    mem_lat = 2; i_address = 16'h0500; i_read = 1'b1;
    wait_resp(0, c);
    chk("t6_recover_latency", 128'(c), 128'(3));
    chk("t6_recover_rdata", i_rdata, line_of(16'h0500));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (fetch side) and the data cache (MEM/WB side) of the LC-3b pipeline.
- Grants one requester per transaction with round-robin fairness.
- Registers the memory command for the whole transaction and returns the fetched line plus a one-cycle response to the granted cache only.
- Sits between both caches and pmem.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  LINE_WIDTH  line returned to the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  write-back line.
- d_rdata  out  LINE_WIDTH  line returned to the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  memory read command, registered.
- pmem_write  out  1  memory write command, registered.
- pmem_address  out  ADDR_WIDTH  registered memory address.
- pmem_wdata  out  LINE_WIDTH  registered write line.
- pmem_rdata  in  LINE_WIDTH  memory read line.
- pmem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state <= IDLE, last_grant <= I.
  - All outputs <= 0.
  - A reset mid-transaction aborts it: pmem_read and pmem_write are low from the next cycle, and no resp is issued.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, arbitration:
  - req_i = i_read; req_d = d_read | d_write.
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_grant. After reset this means D wins first.
  - On grant, in the same edge:
    - Capture the address into pmem_address.
    - For D, capture d_wdata into pmem_wdata.
    - Assert pmem_read, or pmem_write for a D write.
    - Update last_grant.
    - Move to BUSY_x.
  - No request: stay in IDLE with commands low.
- d_read and d_write both high is illegal. The arbiter treats it as a write and must not hang.
- BUSY_x:
  - Hold pmem_* unchanged until pmem_resp=1.
  - On pmem_resp: drop pmem_read/pmem_write, latch pmem_rdata into x_rdata (reads only; d_rdata is unchanged on a write), move to RESP_x.
  - Request inputs are ignored while busy. A request that drops mid-transaction still completes in memory, and the resp pulse is still issued.
- RESP_x:
  - x_resp=1 for exactly this one cycle, then go to IDLE.
  - The requester drops its request on the same edge, so the completed request is never re-granted.
- x_rdata holds its value until the next read completion for that side.
- Latency with an N-cycle memory (pmem_resp in the Nth BUSY cycle):
  - Request seen in IDLE at edge t → pmem command visible in cycle t+1.
  - x_resp in cycle t+N+1.
  - Next grant possible at edge t+N+2.
- At most one of pmem_read/pmem_write is high; at most one of i_resp/d_resp is high.

Decomposition:
- Shared package lc3b_types holds:
  - lc3b_word (already present).
  - lc3b_c_line, LINE_WIDTH bits.
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D}.
  - arb_grant_t enum {GRANT_I, GRANT_D}.
- One natural sub-module, rr_grant2: a combinational 2-way round-robin picker (req_i, req_d, last_grant → grant_valid, grant). This keeps the FSM free of priority logic.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while i_read=1 → all outputs 0; after release, first grant is I (only requester), with pmem_read=1 and pmem_address=0x1230 one cycle later.
2. I-read alone, address 0x0040, memory returns 0xDEAD_BEEF_... after 3 cycles → i_rdata = that line, i_resp high exactly 1 cycle, d_resp stays 0, pmem_read low in the RESP_I cycle.
3. i_read and d_read asserted in the same cycle after reset → D granted first (address 0x8000), I granted immediately after d_resp; the next simultaneous conflict grants I, showing alternation.
4. D write-back to 0x0100 with d_wdata=0x0123_4567_89AB_CDEF_... → pmem_write=1, pmem_wdata matches, d_resp after pmem_resp; d_rdata unchanged.
5. d_read and d_write both high → handled as a write, completes with d_resp, FSM returns to IDLE.
6. rst_n pulled low in the middle of BUSY_D → next cycle pmem_write=0, state IDLE, no d_resp ever pulses for the aborted transaction; a new request is then served normally.
